// File: rtl/uart_frame_rx.sv
// UART receiver with 16x oversampling, majority-vote bit sampling, parity/frame/break
// detection and a small show-ahead receive FIFO.
module uart_frame_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic                 Parity_Error,
    output logic                 Frame_Error,
    output logic                 Overrun,
    output logic                 Break_Detect
);
    localparam int OsDiv = CLOCK_FREQ / (BAUD * 16) - 1;
    localparam int OsW   = (OsDiv < 1) ? 1 : $clog2(OsDiv + 1);
    localparam int PtrW  = $clog2(FIFO_DEPTH);
    localparam int CntW  = PtrW + 1;
    localparam int EntW  = DATA_BITS + 2;

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreakWait
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [1:0]           warm_q, warm_d;
    logic                 armed_q, armed_d;
    logic [OsW-1:0]       os_cnt_q, os_cnt_d;
    logic [3:0]           phase_q, phase_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 brk_q, brk_d;
    logic                 push_q, push_d;
    logic [EntW-1:0]      push_ent_q, push_ent_d;
    logic                 brk_pulse_q, brk_pulse_d;
    logic [EntW-1:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [EntW-1:0]      head;
    logic tick, maj, mid, last, brk_now, frm_now, full, pop, wr_en;

    always_comb begin
        tick    = (state_q != StIdle) && (os_cnt_q == OsW'(OsDiv));
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
        mid     = tick && (phase_q == 4'd9);
        last    = tick && (phase_q == 4'd15);
        // A second stop bit inherits the break verdict already taken at the first one.
        brk_now = brk_q & (stop_cnt_q | ~maj);
        frm_now = frm_err_q | ~maj;

        state_d     = state_q;
        warm_d      = {warm_q[0], 1'b1};
        armed_d     = armed_q | (warm_q[1] & sync2_q);
        os_cnt_d    = (state_q == StIdle || tick) ? '0 : os_cnt_q + OsW'(1);
        phase_d     = tick ? phase_q + 4'd1 : phase_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_ent_d  = push_ent_q;
        brk_pulse_d = 1'b0;

        if (tick && phase_q == 4'd7) samp_d[0] = sync2_q;
        if (tick && phase_q == 4'd8) samp_d[1] = sync2_q;

        case (state_q)
            StIdle: begin
                // armed_q keeps a line that is low straight out of reset from starting a frame
                if (armed_q && !sync2_q) begin
                    state_d    = StStart;
                    os_cnt_d   = '0;
                    phase_d    = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    brk_d      = 1'b1;
                end
            end
            StStart: begin
                if (mid && maj) state_d = StIdle;
                else if (last)  state_d = StData;
            end
            StData: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (maj) brk_d = 1'b0;
                end
                if (last) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (mid) begin
                    if ((^shift_q ^ maj) != (PARITY == 1)) par_err_d = 1'b1;
                    if (maj) brk_d = 1'b0;
                end
                if (last) state_d = StStop;
            end
            StStop: begin
                if (mid) begin
                    frm_err_d = frm_now;
                    brk_d     = brk_now;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        push_d      = 1'b1;
                        push_ent_d  = {shift_q, par_err_q, frm_now};
                        brk_pulse_d = brk_now;
                        state_d     = brk_now ? StBreakWait : StIdle;
                    end
                end else if (last) begin
                    stop_cnt_d = 1'b1;
                end
            end
            StBreakWait: begin
                if (sync2_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        Rx_Valid     = (count_q != '0);
        full         = (count_q == CntW'(FIFO_DEPTH));
        pop          = Rx_Valid & Rx_Ready;
        wr_en        = push_q & (~full | pop);
        Overrun      = push_q & full & ~pop;
        Break_Detect = brk_pulse_q;
        Rx_Data      = Rx_Valid ? head[EntW-1:2] : '0;
        Parity_Error = Rx_Valid & head[1];
        Frame_Error  = Rx_Valid & head[0];

        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + CntW'(1);
        else if (pop && !wr_en) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            os_cnt_q    <= '0;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            samp_q      <= '1;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_ent_q  <= '0;
            brk_pulse_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            os_cnt_q    <= os_cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_ent_q  <= push_ent_d;
            brk_pulse_q <= brk_pulse_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_ent_q;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed scenarios plus randomized frames checked against a
// frame-level model (expected entries queue, overrun and break counts).
module tb_uart_frame_rx;
    localparam int Bit = 160;  // clocks per bit at 18.432 MHz / 115200

    logic       Clk = 1'b0, Reset = 1'b1, uart_rx = 1'b1, Rx_Ready = 1'b0;
    logic [7:0] Rx_Data;
    logic       Rx_Valid, Parity_Error, Frame_Error, Overrun, Break_Detect;

    int err_cnt = 0, chk_cnt = 0;
    int ovr_cnt = 0, brk_cnt = 0, exp_ovr = 0, exp_brk = 0;
    logic [9:0] exp_q[$];

    always #5 Clk = ~Clk;

    uart_frame_rx #(
        .CLOCK_FREQ(18_432_000), .BAUD(115200), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .uart_rx(uart_rx),
        .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Ready(Rx_Ready),
        .Parity_Error(Parity_Error), .Frame_Error(Frame_Error),
        .Overrun(Overrun), .Break_Detect(Break_Detect)
    );

    always @(negedge Clk) begin
        if (Overrun) ovr_cnt++;
        if (Break_Detect) brk_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Expected receiver outcome of one frame, from the even-parity, stop and break rules.
    task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stop);
        logic perr, ferr;
        perr = (^d) ^ pbit;
        ferr = ~stop;
        if (d == 8'h00 && !pbit && !stop) exp_brk++;
        if (exp_q.size() < 4) exp_q.push_back({d, perr, ferr});
        else exp_ovr++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int bclk);
        logic [10:0] fr;
        model_frame(d, pbit, stop);
        fr = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_rx = fr[i];
            hold(bclk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        @(negedge Clk);
        check_eq({tag, "_valid"}, 32'(Rx_Valid), 32'd1);
        check_eq({tag, "_data"}, 32'(Rx_Data), 32'(e[9:2]));
        check_eq({tag, "_perr"}, 32'(Parity_Error), 32'(e[1]));
        check_eq({tag, "_ferr"}, 32'(Frame_Error), 32'(e[0]));
        Rx_Ready = 1'b1;
        @(posedge Clk);
        #1 Rx_Ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        hold(2);
        @(negedge Clk);
        check_eq({tag, "_empty"}, 32'(Rx_Valid), 32'd0);
    endtask

    initial begin
        int ovr0, brk0, bclk;
        logic [7:0] d;
        logic pbit, stop;

        hold(3);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("rst_valid", 32'(Rx_Valid), 32'd0);
        check_eq("rst_data", 32'(Rx_Data), 32'd0);
        check_eq("rst_perr", 32'(Parity_Error), 32'd0);
        check_eq("rst_ferr", 32'(Frame_Error), 32'd0);
        check_eq("rst_ovr", 32'(Overrun), 32'd0);
        check_eq("rst_brk", 32'(Break_Detect), 32'd0);
        hold(Bit);

        // Good frame, then parity error and frame error frames
        d = 8'hA5;
        send_frame(d, ^d, 1'b1, Bit);
        hold(Bit);
        drain("s1");
        send_frame(8'h3C, 1'b1, 1'b1, Bit);
        hold(Bit);
        send_frame(8'h55, 1'b0, 1'b0, Bit);
        hold(2 * Bit);
        drain("s2");

        // Five back-to-back frames into a 4-deep FIFO with no consumer
        ovr0 = ovr_cnt;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k);
            if (k == 5) check_eq("s3_ovr_before5", 32'(ovr_cnt - ovr0), 32'd0);
            send_frame(d, ^d, 1'b1, Bit);
        end
        hold(Bit);
        check_eq("s3_ovr_once", 32'(ovr_cnt - ovr0), 32'd1);
        drain("s3");

        // Break: line low for 12 bit times
        brk0 = brk_cnt;
        model_frame(8'h00, 1'b0, 1'b0);
        uart_rx = 1'b0;
        hold(12 * Bit);
        uart_rx = 1'b1;
        hold(4 * Bit);
        check_eq("s4_brk_once", 32'(brk_cnt - brk0), 32'd1);
        drain("s4");

        // Short glitch, then +/-2% baud streams
        uart_rx = 1'b0;
        hold(40);
        uart_rx = 1'b1;
        hold(3 * Bit);
        @(negedge Clk);
        check_eq("s5_glitch_valid", 32'(Rx_Valid), 32'd0);
        d = 8'hC3;
        send_frame(d, ^d, 1'b1, 157);
        hold(2 * Bit);
        send_frame(d, ^d, 1'b1, 163);
        hold(2 * Bit);
        drain("s5");

        // Reset during data bit 4 with an entry already queued
        d = 8'h5A;
        send_frame(d, ^d, 1'b1, Bit);
        hold(Bit);
        d = 8'h2B;
        uart_rx = 1'b0;
        hold(Bit);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d[i];
            hold(Bit);
        end
        uart_rx = d[4];
        hold(80);
        Reset = 1'b1;
        hold(1);
        Reset = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        check_eq("s6_rst_valid", 32'(Rx_Valid), 32'd0);
        check_eq("s6_rst_data", 32'(Rx_Data), 32'd0);
        hold(79);
        uart_rx = 1'b1;
        hold(3 * Bit);
        @(negedge Clk);
        check_eq("s6_nopush", 32'(Rx_Valid), 32'd0);
        d = 8'h7E;
        send_frame(d, ^d, 1'b1, Bit);
        hold(Bit);
        drain("s6");

        // Randomized frames: data, parity corruption, stop errors, baud skew, sparse draining
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 2))
                0:       bclk = 157;
                1:       bclk = 163;
                default: bclk = Bit;
            endcase
            if (!stop) bclk = Bit;
            send_frame(d, pbit, stop, bclk);
            hold(Bit * (1 + int'($urandom_range(0, 1))));
            if ($urandom_range(0, 2) == 0 || n == 9) drain("rnd");
        end

        check_eq("ovr_total", 32'(ovr_cnt), 32'(exp_ovr));
        check_eq("brk_total", 32'(brk_cnt), 32'(exp_brk));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
